// File: rtl/tb_sequencer.sv
// Run controller for the arithmetic testbench: Avalon-MM CSRs, randomiser
// enable gating, scoreboard clear, drain wait and event-count snapshot.
//
// Bus handshake: there is no waitrequest. A cycle is an access only when
// exactly one of slave_read / slave_write is high at the rising clk edge.
// Writes take effect at that edge. Read data appears on slave_readdata after
// that edge and holds until the next valid read. When both strobes are high,
// nothing happens and slave_readdata holds.
module tb_sequencer #(
    parameter int WIDTH        = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int EVT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       slave_address,
    input  logic             slave_read,
    input  logic             slave_write,
    input  logic [WIDTH-1:0] slave_writedata,
    output logic [WIDTH-1:0] slave_readdata,
    input  logic [EVT_W-1:0] i_event_ctr,
    output logic             o_gen_enable,
    output logic             o_sb_clear,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_LEN    = 4'h4;
    localparam logic [3:0] ADDR_ISSUED = 4'h8;
    localparam logic [3:0] ADDR_EVENTS = 4'hC;

    state_t           state, state_nx;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_lat;
    logic [WIDTH-1:0] run_cnt;
    logic [WIDTH-1:0] issued_q;
    logic [WIDTH-1:0] events_q;
    logic [DW-1:0]    drain_cnt;

    logic wr_acc, rd_acc, ctrl_wr, start_cmd, abort_cmd, enter_clear;

    // Bus access decode; abort dominates start in the same CTRL write.
    always_comb begin
        wr_acc    = slave_write && !slave_read;
        rd_acc    = slave_read && !slave_write;
        ctrl_wr   = wr_acc && (slave_address == ADDR_CTRL);
        abort_cmd = ctrl_wr && slave_writedata[1];
        start_cmd = ctrl_wr && slave_writedata[0] && !slave_writedata[1];
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        o_gen_enable = (state == ST_RUN);
        o_sb_clear   = (state == ST_CLEAR);
        o_busy       = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
        o_done       = (state == ST_DONE);
        dbg_state    = state;
    end

    // Next-state logic; a zero-length start is ignored.
    always_comb begin
        state_nx    = state;
        enter_clear = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_cmd && (len_q != '0)) begin
                    state_nx    = ST_CLEAR;
                    enter_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_nx = abort_cmd ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort_cmd)
                    state_nx = ST_IDLE;
                else if (run_cnt == len_lat - WIDTH'(1))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_cmd)
                    state_nx = ST_IDLE;
                else if (drain_cnt == DRAIN_LAST)
                    state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // LEN register; frozen while a run is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            len_q <= '0;
        else if (wr_acc && (slave_address == ADDR_LEN) && !o_busy)
            len_q <= slave_writedata;
    end

    // Run bookkeeping: length latch, run/drain counters, ISSUED and EVENTS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lat   <= '0;
            run_cnt   <= '0;
            issued_q  <= '0;
            events_q  <= '0;
            drain_cnt <= '0;
        end else begin
            if (enter_clear) begin
                len_lat  <= len_q;
                run_cnt  <= '0;
                issued_q <= '0;
                events_q <= '0;
            end else if (state == ST_RUN) begin
                // The cycle in which abort is sampled was still enabled, so it counts.
                run_cnt <= run_cnt + WIDTH'(1);
                if (issued_q != '1)
                    issued_q <= issued_q + WIDTH'(1);
            end

            if (state == ST_DRAIN && state_nx == ST_DONE)
                events_q <= WIDTH'(i_event_ctr);

            if (state == ST_DRAIN)
                drain_cnt <= drain_cnt + DW'(1);
            else
                drain_cnt <= '0;
        end
    end

    // Registered read data; holds when there is no valid read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slave_readdata <= '0;
        end else if (rd_acc) begin
            case (slave_address)
                ADDR_CTRL:   slave_readdata <= WIDTH'({state, o_done, o_busy});
                ADDR_LEN:    slave_readdata <= len_q;
                ADDR_ISSUED: slave_readdata <= issued_q;
                ADDR_EVENTS: slave_readdata <= events_q;
                default:     slave_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_sequencer.sv
// Directed bench for tb_sequencer: CSR access, run timing, abort, zero length,
// strobe collision, back-to-back runs and asynchronous reset.
module tb_tb_sequencer;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_LEN    = 4'h4;
    localparam logic [3:0] A_ISSUED = 4'h8;
    localparam logic [3:0] A_EVENTS = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic [7:0]  i_event_ctr;
    logic        o_gen_enable;
    logic        o_sb_clear;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    tb_sequencer #(.WIDTH(32), .DRAIN_CYCLES(4), .EVT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_address   (slave_address),
        .slave_read      (slave_read),
        .slave_write     (slave_write),
        .slave_writedata (slave_writedata),
        .slave_readdata  (slave_readdata),
        .i_event_ctr     (i_event_ctr),
        .o_gen_enable    (o_gen_enable),
        .o_sb_clear      (o_sb_clear),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .dbg_state       (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled at the posedge between the two negedges; returns in the next cycle.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        slave_address   = addr;
        slave_writedata = data;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        slave_address = addr;
        slave_read    = 1'b1;
        @(negedge clk);
        slave_read    = 1'b0;
        data          = slave_readdata;
    endtask

    // Step negedges from cycle index t0 until o_done; -1 on timeout.
    task automatic wait_done(input int t0, output int t_done);
        int t;
        t = t0;
        while (!o_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        t_done = o_done ? t : -1;
    endtask

    initial begin
        logic [31:0] rd;
        int t, en_cnt, clr_cnt, t_done;
        bit en_seen;

        reset           = 1'b0;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        i_event_ctr     = 8'd3;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state and all registers reading zero.
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_en", 32'(o_gen_enable), 32'd0);
        check("rst_rdata", slave_readdata, 32'd0);
        bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
        bus_read(A_LEN, rd);    check("rst_len", rd, 32'd0);
        bus_read(A_ISSUED, rd); check("rst_issued", rd, 32'd0);
        bus_read(A_EVENTS, rd); check("rst_events", rd, 32'd0);

        // LEN=10 run: done 16 cycles after the start edge.
        bus_write(A_LEN, 32'd10);
        bus_write(A_CTRL, 32'h1);
        t = 1;
        check("r10_clear_t1", 32'(o_sb_clear), 32'd1);
        check("r10_busy_t1", 32'(o_busy), 32'd1);
        en_cnt  = o_gen_enable ? 1 : 0;
        clr_cnt = o_sb_clear ? 1 : 0;
        while (!o_done && t < 100) begin
            @(negedge clk);
            t++;
            if (o_gen_enable) en_cnt++;
            if (o_sb_clear) clr_cnt++;
        end
        check("r10_done_t", 32'(t), 32'd16);
        check("r10_en_cnt", 32'(en_cnt), 32'd10);
        check("r10_clr_cnt", 32'(clr_cnt), 32'd1);
        check("r10_busy_done", 32'(o_busy), 32'd0);
        bus_read(A_ISSUED, rd); check("r10_issued", rd, 32'd10);
        bus_read(A_EVENTS, rd); check("r10_events", rd, 32'd3);
        bus_read(A_CTRL, rd);   check("r10_ctrl", rd, 32'h12);

        // LEN=100 with abort after 20 RUN cycles; LEN write mid-run ignored.
        bus_write(A_LEN, 32'd100);
        bus_write(A_CTRL, 32'h1);
        t = 1;
        bus_write(A_LEN, 32'd55);
        t = 3;
        while (t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ab_en_t20", 32'(o_gen_enable), 32'd1);
        bus_write(A_CTRL, 32'h2);
        check("ab_en_off", 32'(o_gen_enable), 32'd0);
        check("ab_state", 32'(dbg_state), 32'd0);
        repeat (8) @(negedge clk);
        check("ab_done", 32'(o_done), 32'd0);
        bus_read(A_ISSUED, rd); check("ab_issued", rd, 32'd20);
        bus_read(A_EVENTS, rd); check("ab_events", rd, 32'd0);
        bus_read(A_LEN, rd);    check("ab_len", rd, 32'd100);
        bus_write(A_CTRL, 32'h2);
        check("ab_idle_abort", 32'(dbg_state), 32'd0);

        // Start with LEN=0 is ignored.
        bus_write(A_LEN, 32'd0);
        bus_write(A_CTRL, 32'h1);
        en_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_gen_enable || o_busy) en_seen = 1'b1;
            @(negedge clk);
        end
        check("z_no_run", 32'(en_seen), 32'd0);
        check("z_state", 32'(dbg_state), 32'd0);

        // Simultaneous read+write is no access; start|abort leaves state alone.
        bus_write(A_LEN, 32'd7);
        bus_read(A_ISSUED, rd); check("col_pre", rd, 32'd20);
        @(negedge clk);
        slave_address   = A_LEN;
        slave_writedata = 32'd99;
        slave_read      = 1'b1;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        check("col_rdata_hold", slave_readdata, 32'd20);
        bus_write(A_CTRL, 32'h3);
        check("col_sa_clear", 32'(o_sb_clear), 32'd0);
        check("col_sa_state", 32'(dbg_state), 32'd0);
        bus_read(A_LEN, rd); check("col_len", rd, 32'd7);

        // LEN=5 twice: second start clears ISSUED/EVENTS, then repeats.
        bus_write(A_LEN, 32'd5);
        i_event_ctr = 8'd9;
        bus_write(A_CTRL, 32'h1);
        wait_done(1, t_done);
        check("b1_done_t", 32'(t_done), 32'd11);
        bus_read(A_ISSUED, rd); check("b1_issued", rd, 32'd5);
        bus_read(A_EVENTS, rd); check("b1_events", rd, 32'd9);
        i_event_ctr = 8'd11;
        bus_write(A_CTRL, 32'h1);
        bus_read(A_ISSUED, rd); check("b2_issued_clr", rd, 32'd0);
        bus_read(A_EVENTS, rd); check("b2_events_clr", rd, 32'd0);
        wait_done(5, t_done);
        check("b2_done_t", 32'(t_done), 32'd11);
        bus_read(A_ISSUED, rd); check("b2_issued", rd, 32'd5);
        bus_read(A_EVENTS, rd); check("b2_events", rd, 32'd11);

        // Asynchronous reset in the middle of a run.
        bus_write(A_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        check("ar_pre_en", 32'(o_gen_enable), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_en", 32'(o_gen_enable), 32'd0);
        check("ar_busy", 32'(o_busy), 32'd0);
        check("ar_state", 32'(dbg_state), 32'd0);
        check("ar_rdata", slave_readdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_LEN, rd);    check("ar_len", rd, 32'd0);
        bus_read(A_EVENTS, rd); check("ar_events", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tb_sequencer.md
# tb_sequencer

Run controller for the arithmetic testbench. It owns the Avalon-MM control/status registers through which the host starts a test run of a programmed length. It gates the randomiser enable for exactly that many cycles, clears the scoreboard before each run, and waits a drain period for in-flight DUT results. It then snapshots the scoreboard event count for the host. It sits between the Avalon slave and the randomiser/scoreboard, in the testbench clock domain.

## Interface
- WIDTH, 32, data width of the Avalon bus and the LEN/ISSUED registers
- DRAIN_CYCLES, 4, cycles waited after the last enabled cycle before results are captured (≥1)
- EVT_W, 8, width of the scoreboard event counter input
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset
- slave_address  in  4  byte address: 0x0 CTRL, 0x4 LEN, 0x8 ISSUED, 0xC EVENTS
- slave_read  in  1  read strobe
- slave_write  in  1  write strobe
- slave_writedata  in  WIDTH  write data
- slave_readdata  out  WIDTH  registered read data
- i_event_ctr  in  EVT_W  scoreboard event count
- o_gen_enable  out  1  randomiser enable; high only in RUN
- o_sb_clear  out  1  one-cycle scoreboard clear pulse
- o_busy  out  1  high in CLEAR, RUN, DRAIN
- o_done  out  1  high in DONE

## Operation
- Access is valid only when exactly one of slave_read/slave_write is high. Both high means no action, and slave_readdata holds its value.
- CTRL write: bit0 = start, bit1 = abort. Other bits are ignored. Bits are self-clearing commands and are not stored.
- CTRL read: {zeros, state[2:0] at bits 4:2, done at bit1, busy at bit0}.
- LEN: R/W. Writes are ignored while o_busy=1.
- ISSUED: read-only count of enabled cycles in the current/last run. Cleared on entry to CLEAR.
- EVENTS: read-only, zero-extended snapshot of i_event_ctr taken on entry to DONE. Cleared on entry to CLEAR.
- Unmapped addresses read 0. Writes to read-only registers are ignored.
- FSM states (encoding): IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4.
  - IDLE/DONE, start with LEN≠0 -> CLEAR.
  - IDLE/DONE, start with LEN=0 -> ignored; no state change.
  - CLEAR -> RUN unconditionally after 1 cycle; o_sb_clear=1 in this cycle only.
  - RUN: o_gen_enable=1 and ISSUED+1 each cycle. After the LEN-th cycle -> DRAIN.
  - DRAIN: counts DRAIN_CYCLES cycles -> DONE, capturing EVENTS on the transition.
  - DONE holds until the next start.
- Abort in CLEAR/RUN/DRAIN -> IDLE next cycle. o_gen_enable drops immediately, ISSUED is frozen, EVENTS is not captured, and done is not set.
- Abort in IDLE/DONE: ignored.
- Start while busy: ignored.
- Start and abort in the same write: abort wins.
- ISSUED saturates at 2^WIDTH−1, which cannot occur while LEN ≤ 2^WIDTH−1. The internal run counter is WIDTH bits and compares against LEN latched at CLEAR.

## Timing
- Reset values:
  - state IDLE
  - slave_readdata, LEN, ISSUED, EVENTS all 0
  - o_gen_enable, o_sb_clear, o_busy, o_done all 0
- Register writes take effect at the clk edge where slave_write is sampled.
- Reads: slave_readdata is valid the cycle after the edge where slave_read is sampled (1-cycle latency).
- Start write sampled at edge N gives:
  - CLEAR in cycle N+1.
  - RUN for cycles N+2 … N+1+LEN.
  - DRAIN for the next DRAIN_CYCLES cycles.
  - DONE from cycle N+2+LEN+DRAIN_CYCLES.
- Total latency from start to o_done is LEN+DRAIN_CYCLES+2 cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational path from slave_* to o_*.
- Asynchronous reset mid-run returns to IDLE immediately, and all outputs go to their reset values.

## Test plan
- Reset, then read all four addresses -> all read 0; o_busy=o_done=0.
- Write LEN=10, start; hold i_event_ctr=3 -> o_sb_clear is high for 1 cycle, o_gen_enable is high for exactly 10 cycles, and o_done rises 16 cycles after start (DRAIN_CYCLES=4). ISSUED reads 10, EVENTS reads 3.
- Start with LEN=0 -> state stays IDLE and o_gen_enable never rises.
- LEN=100, start, abort after 20 RUN cycles -> IDLE next cycle. ISSUED=20, o_done=0, EVENTS=0. LEN write during RUN is ignored (LEN still 100).
- Simultaneous read+write to LEN, then a write of start|abort -> LEN unchanged, readdata unchanged, state unchanged.
- Run LEN=5 to DONE, then start again -> ISSUED and EVENTS clear in CLEAR, and the second run completes identically.
